booth_mul_iter: RTL and testbench

Parametrised iterative radix-4 Booth multiplier that produces one partial product per cycle into a 2·XLEN-bit accumulator. It supports full-width and half-width (word) modes and all four signedness combinations. It adds a flush and a two-sided valid/ready handshake with output backpressure. It sits in the EXU as the multi-cycle multiply unit behind the MUL/MULH/MULHSU/MULHU/MULW decode path.

---
 rtl/booth_mul_iter.sv | 94 +++++++++
 tb/tb_booth_mul_iter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier, one partial product per cycle
//   clock, reset_n         : rising-edge clock, async active-low reset
//   flush                  : cancel any operation in flight
//   in_valid / in_ready    : operand handshake (ready only when idle)
//   mulw                   : word mode (HALF x HALF, results sign-extended)
//   mul_signed             : [1] multiplicand signed, [0] multiplier signed
//   multiplicand/multiplier: operands, sampled on accept only
//   out_valid / out_ready  : result handshake, result held until accepted
//   result_hi / result_lo  : product halves, zero while out_valid is low
module booth_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);
  localparam int HALF = XLEN / 2;
  localparam int CW = $clog2(HALF + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [2*XLEN-1:0] acc, mcand, mag, pp, acc_nxt;
  logic [XLEN+2:0] mplr;
  logic [CW-1:0] cnt;
  logic [2:0] d;
  logic w, last, sa, sb;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == (w ? CW'(HALF / 2) : CW'(HALF));
  assign sa = mul_signed[1] & (mulw ? multiplicand[HALF-1] : multiplicand[XLEN-1]);
  assign sb = mul_signed[0] & (mulw ? multiplier[HALF-1] : multiplier[XLEN-1]);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else if (state == IDLE && in_valid) state_nxt = BUSY;
    else if (state == BUSY && last) state_nxt = DONE;
    else if (state == DONE && out_ready) state_nxt = IDLE;
  end
  // Booth digit from the low 3 multiplier bits; mcand is pre-shifted by 2*i,
  // so the partial product needs no variable shifter.
  always_comb begin
    d = mplr[2:0];
    mag = (d == 3'b011 || d == 3'b100) ? mcand << 1 : (d == 3'b000 || d == 3'b111) ? '0 : mcand;
    pp = d[2] ? -mag : mag;
    acc_nxt = acc + pp;
  end
  // Word-mode operands are extended all the way to the full datapath width;
  // the extra Booth digits would all be zero, so only HALF/2+1 iterations run.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
      w <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else if (state == IDLE && in_valid) begin
      acc <= '0;
      cnt <= '0;
      w <= mulw;
      mcand <= mulw ? {{(XLEN+HALF){sa}}, multiplicand[HALF-1:0]} : {{XLEN{sa}}, multiplicand};
      mplr <= mulw ? {{(HALF+2){sb}}, multiplier[HALF-1:0], 1'b0} : {{2{sb}}, multiplier, 1'b0};
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      mcand <= mcand << 2;
      mplr <= {{2{mplr[XLEN+2]}}, mplr[XLEN+2:2]};
      cnt <= cnt + CW'(1);
      if (last) begin
        result_hi <= w ? {{HALF{acc_nxt[XLEN-1]}}, acc_nxt[XLEN-1:HALF]} : acc_nxt[2*XLEN-1:XLEN];
        result_lo <= w ? {{HALF{acc_nxt[HALF-1]}}, acc_nxt[HALF-1:0]} : acc_nxt[XLEN-1:0];
      end
    end else if (state == DONE && out_ready) begin
      result_hi <= '0;
      result_lo <= '0;
    end
endmodule

// File: tb/tb_booth_mul_iter.sv
// tb_booth_mul_iter: randomized and directed checks of booth_mul_iter against an arithmetic model
module tb_booth_mul_iter;
  localparam int XLEN = 64;
  localparam logic [63:0] TA [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_7FFF_FFFF};
  localparam logic [63:0] TB [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd2, 64'd2, 64'd2};
  localparam logic [1:0] TS [5] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
  localparam logic TW [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [63:0] EH [5] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0};
  localparam logic [63:0] EL [5] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1,
                                     64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, mulw = 1'b0, out_ready = 1'b1;
  logic [1:0] mul_signed = 2'b00;
  logic [63:0] multiplicand = '0, multiplier = '0;
  logic in_ready, out_valid;
  logic [63:0] result_hi, result_lo;
  int n_cmp = 0, n_err = 0;
  always #5 clock = ~clock;
  booth_mul_iter #(.XLEN(XLEN)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mulw(mulw), .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .result_hi(result_hi), .result_lo(result_lo)
  );
  function automatic void ref_mul(input logic w, input logic [1:0] ms, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] hi, output logic [63:0] lo);
    logic [127:0] ea, eb, p;
    if (w) begin
      ea = ms[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      eb = ms[0] ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      p = ea * eb;
      lo = {{32{p[31]}}, p[31:0]};
      hi = {{32{p[63]}}, p[63:32]};
    end else begin
      ea = ms[1] ? {{64{a[63]}}, a} : {64'b0, a};
      eb = ms[0] ? {{64{b[63]}}, b} : {64'b0, b};
      p = ea * eb;
      hi = p[127:64];
      lo = p[63:0];
    end
  endfunction
  function automatic logic [63:0] pick();
    int k;
    k = int'($urandom_range(4, 0));
    return k == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : k == 1 ? 64'h8000_0000_0000_0000 :
           k == 2 ? 64'(int'($urandom_range(20, 0))) : {$urandom(), $urandom()};
  endfunction
  // Drives one accept with out_ready high; returns the result, edges from accept to
  // out_valid (-1 on timeout) and how many busy samples showed in_ready or non-zero results.
  task automatic do_op(input logic w, input logic [1:0] ms, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] hi, output logic [63:0] lo, output int lat, output int viol);
    hi = '0;
    lo = '0;
    lat = -1;
    viol = 0;
    mulw = w;
    mul_signed = ms;
    multiplicand = a;
    multiplier = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    mulw = 1'($urandom());
    mul_signed = 2'($urandom());
    multiplicand = {$urandom(), $urandom()};
    multiplier = {$urandom(), $urandom()};
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = i;
        hi = result_hi;
        lo = result_lo;
        break;
      end
      if (in_ready || result_hi != 0 || result_lo != 0) viol++;
    end
    if (lat > 0) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({result_hi, result_lo} !== 128'h0) begin n_err++; $display("FAIL reset_result: got %h_%h expected 0", result_hi, result_lo); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid); end
  endtask
  task automatic test_directed();
    logic [63:0] hi, lo;
    int lat, viol;
    for (int i = 0; i < 5; i++) begin
      do_op(TW[i], TS[i], TA[i], TB[i], hi, lo, lat, viol);
      n_cmp++; if (hi !== EH[i]) begin n_err++; $display("FAIL directed%0d_hi: got %h expected %h", i, hi, EH[i]); end
      n_cmp++; if (lo !== EL[i]) begin n_err++; $display("FAIL directed%0d_lo: got %h expected %h", i, lo, EL[i]); end
      n_cmp++; if (lat != (TW[i] ? 17 : 33)) begin n_err++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, TW[i] ? 17 : 33); end
      n_cmp++; if (viol != 0) begin n_err++; $display("FAIL directed%0d_busy_outputs: got %0d bad samples expected 0", i, viol); end
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL directed%0d_return_idle: got rdy=%b vld=%b expected rdy=1 vld=0", i, in_ready, out_valid); end
    end
  endtask
  task automatic test_flush();
    logic [63:0] hi, lo;
    int lat, viol, seen;
    mulw = 1'b0; mul_signed = 2'b11; multiplicand = 64'd7; multiplier = 64'd6;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_beats_accept: got rdy=%b expected 1", in_ready); end
    multiplicand = 64'h1234_5678_9ABC_DEF0; multiplier = 64'h0FED_CBA9_8765_4321; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_busy_state: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid); end
    n_cmp++; if ({result_hi, result_lo} !== 128'h0) begin n_err++; $display("FAIL flush_busy_result: got %h_%h expected 0", result_hi, result_lo); end
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); end
    do_op(1'b0, 2'b11, 64'd7, 64'd6, hi, lo, lat, viol);
    n_cmp++; if (lo !== 64'd42 || hi !== 64'd0) begin n_err++; $display("FAIL flush_followup: got %h_%h expected 0_2a", hi, lo); end
    out_ready = 1'b0; mulw = 1'b1; multiplicand = 64'd3; multiplier = 64'd3; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin lat = i; break; end
    end
    n_cmp++; if (lat != 17) begin n_err++; $display("FAIL flush_done_latency: got %0d expected 17", lat); end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || {result_hi, result_lo} !== 128'h0) begin
      n_err++; $display("FAIL flush_done: got rdy=%b vld=%b res=%h_%h expected rdy=1 vld=0 res=0", in_ready, out_valid, result_hi, result_lo);
    end
  endtask
  task automatic test_backpressure();
    logic [63:0] a, b, ehi, elo;
    int lat, bad;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    ref_mul(1'b0, 2'b10, a, b, ehi, elo);
    out_ready = 1'b0; mulw = 1'b0; mul_signed = 2'b10; multiplicand = a; multiplier = b; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin lat = i; break; end
    end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL bp_latency: got %0d expected 33", lat); end
    n_cmp++; if (result_hi !== ehi || result_lo !== elo) begin n_err++; $display("FAIL bp_result: got %h_%h expected %h_%h", result_hi, result_lo, ehi, elo); end
    in_valid = 1'b1; multiplicand = 64'd9; multiplier = 64'd9;
    bad = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_hi !== ehi || result_lo !== elo) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || {result_hi, result_lo} !== 128'h0) begin
      n_err++; $display("FAIL bp_release: got rdy=%b vld=%b res=%h_%h expected rdy=1 vld=0 res=0", in_ready, out_valid, result_hi, result_lo);
    end
  endtask
  task automatic test_async_reset();
    logic [63:0] a, b, hi, lo, ehi, elo;
    logic w;
    logic [1:0] ms;
    int lat, viol;
    mulw = 1'b0; mul_signed = 2'b00; multiplicand = 64'hFFFF; multiplier = 64'hFFFF; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || {result_hi, result_lo} !== 128'h0) begin
      n_err++; $display("FAIL async_reset: got rdy=%b vld=%b res=%h_%h expected rdy=1 vld=0 res=0", in_ready, out_valid, result_hi, result_lo);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    w = 1'($urandom()); ms = 2'($urandom()); a = pick(); b = pick();
    ref_mul(w, ms, a, b, ehi, elo);
    do_op(w, ms, a, b, hi, lo, lat, viol);
    n_cmp++; if (hi !== ehi || lo !== elo || lat != (w ? 17 : 33)) begin
      n_err++; $display("FAIL after_reset_op: got %h_%h lat=%0d expected %h_%h lat=%0d", hi, lo, lat, ehi, elo, w ? 17 : 33);
    end
  endtask
  task automatic test_random();
    logic [63:0] a, b, hi, lo, ehi, elo;
    logic w;
    logic [1:0] ms;
    int lat, viol;
    for (int n = 0; n < 1500; n++) begin
      w = 1'($urandom()); ms = 2'($urandom()); a = pick(); b = pick();
      ref_mul(w, ms, a, b, ehi, elo);
      do_op(w, ms, a, b, hi, lo, lat, viol);
      n_cmp++; if (hi !== ehi || lo !== elo) begin
        n_err++; $display("FAIL random%0d_result: w=%b s=%b a=%h b=%h got %h_%h expected %h_%h", n, w, ms, a, b, hi, lo, ehi, elo);
      end
      n_cmp++; if (lat != (w ? 17 : 33) || viol != 0) begin
        n_err++; $display("FAIL random%0d_timing: got lat=%0d viol=%0d expected lat=%0d viol=0", n, lat, viol, w ? 17 : 33);
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
